wb_stage_p: RTL and testbench
=============================

Name: wb_stage_p

Overview:
Parametrised write-back stage for the Beta pipeline, successor to the fixed 32-bit write-back block. It holds one retiring instruction in a valid-qualified stage register and selects the result source (memory load data, ALU result, or return PC). Unlike the previous generation, it tolerates variable-latency load data via a wait state with timeout, back-pressures the memory stage, suppresses writes to the zero register, and counts retired instructions. Sits between the memory stage and the register file; also feeds the hazard unit.

Parameters:
DATA_W, 32, datapath width of pc/ir/y/mem data
RA_W, 5, register address width
RC_LSB, 21, LSB of destination field in ir (field = ir[RC_LSB+RA_W-1:RC_LSB])
ZERO_REG, 31, register index whose writes are suppressed
LD_TIMEOUT, 15, max wait cycles for load data (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  memory stage presents an instruction
in_ready  out  1  stage can accept this cycle
op_ld  in  1  instruction is LD/LDR (result from memory)
op_st  in  1  instruction is ST (no register write)
op_jmp  in  1  instruction writes return PC (JMP/BEQ/BNE)
pc  in  DATA_W  return PC of instruction
ir  in  DATA_W  instruction word
y  in  DATA_W  ALU result
mem_rdata  in  DATA_W  load data
mem_rvalid  in  1  mem_rdata valid this cycle
rf_we  out  1  register file write enable
rf_w_addr  out  RA_W  register file write address
rf_w_data  out  DATA_W  register file write data
pend_valid  out  1  stage holds an instruction that will write a register
pend_addr  out  RA_W  destination of pending instruction
ld_err  out  1  one-cycle pulse: load timed out, instruction dropped
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst=1 at edge): v_q=0, state=IDLE, wait counter=0, instret=0, ld_err=0. Consequently rf_we=0, pend_valid=0, in_ready=1. Reset mid-wait discards the held load without writing.
- Stage register: on edge with in_valid && in_ready, it latches pc/ir/y/op_* and sets v_q=1. If no accept while the held instruction completes, v_q clears.
- Completion in the cycle after accept (latency 1):
  - Non-load: completes unconditionally in that cycle.
  - Load: completes when mem_rvalid=1.
- in_ready = !v_q || complete. In_ready is combinational from mem_rvalid, which allows back-to-back accept on completion.
- Source select, priority ld > jmp > y: op_ld -> mem_rdata; op_jmp -> pc_q; else y_q.
- rf_we = v_q && complete && !op_st_q && dest != ZERO_REG. rf_w_addr = dest field of ir_q. rf_w_data is don't-care when rf_we=0.
- pend_valid = v_q && !op_st_q && dest != ZERO_REG. This includes waiting loads. pend_addr = dest.
- FSM states:
  - IDLE: entered when no load is waiting.
  - WAIT_LD: entered when v_q && op_ld_q && !mem_rvalid.
  - In WAIT_LD, the counter increments each cycle without mem_rvalid.
  - If the counter reaches LD_TIMEOUT without data: ld_err pulses for 1 cycle, the instruction is dropped (no write, no instret increment), v_q clears, in_ready=1 in that cycle, and the state returns to IDLE.
  - If mem_rvalid arrives in the same cycle the timeout would fire, the data wins: normal write, no ld_err.
  - The counter clears on leaving WAIT_LD.
- instret increments by 1 on every completion, including stores and ZERO_REG writes. It wraps modulo 2^CNT_W.
- mem_rvalid while no load is held is ignored.

Test Plan:
- Reset mid-wait: hold a load 3 cycles, assert rst -> next cycle rf_we=0, pend_valid=0, in_ready=1, instret=0.
- ALU op: ir dest=5, y=0x1234, no op flags -> 1 cycle later rf_we=1, addr=5, data=0x1234; instret=1. JMP with pc=0x100 -> data=0x100.
- Load, rvalid 4 cycles late: mem_rdata=0xDEADBEEF -> in_ready=0 and pend_valid=1/pend_addr=dest for 3 cycles, then write 0xDEADBEEF with in_ready=1 and the next instruction accepted the same edge.
- Timeout, LD_TIMEOUT=15: no rvalid -> ld_err pulse at wait cycle 15, no write, instret unchanged. Variant with rvalid exactly at cycle 15 -> write occurs, ld_err=0.
- ST, and ALU op with dest=31 -> rf_we=0 for both, pend_valid=0, instret increments by 2.
- Back-to-back stream of 8 ALU ops with in_valid held high -> 8 consecutive writes, in_ready constantly 1, instret=8. Counter wrap checked with CNT_W=4: 17 ops -> instret=1.

Source files
------------

// File: rtl/wb_stage_p.sv
// Beta pipeline write-back stage: result select, load wait with timeout,
// zero-register suppression and retired-instruction counting.
module wb_stage_p #(
  parameter int DATA_W     = 32,
  parameter int RA_W       = 5,
  parameter int RC_LSB     = 21,
  parameter int ZERO_REG   = 31,
  parameter int LD_TIMEOUT = 15,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_ld,
  input  logic              op_st,
  input  logic              op_jmp,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              pend_valid,
  output logic [RA_W-1:0]   pend_addr,
  output logic              ld_err,
  output logic [CNT_W-1:0]  instret
);

  localparam int TW = $clog2(LD_TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    WAIT_LD
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     wcnt_q, wcnt_d;
  logic [TW-1:0]     missed;
  logic              v_q, ld_q, st_q, jmp_q;
  logic [DATA_W-1:0] pc_q, y_q;
  logic [RA_W-1:0]   dest_q;
  logic [CNT_W-1:0]  instret_q;
  logic              wr_ok, complete, timeout, accept, waiting;

  assign wr_ok    = !st_q && (dest_q != RA_W'(ZERO_REG));
  assign complete = v_q && (!ld_q || mem_rvalid);
  assign waiting  = v_q && ld_q && !mem_rvalid;
  // missed = load cycles already elapsed without data
  assign missed   = (state_q == WAIT_LD) ? wcnt_q : '0;
  assign timeout  = waiting && (missed == TW'(LD_TIMEOUT - 1));
  assign in_ready = !v_q || complete || timeout;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = IDLE;
    wcnt_d  = '0;
    case (state_q)
      IDLE, WAIT_LD: begin
        if (waiting && !timeout) begin
          state_d = WAIT_LD;
          wcnt_d  = missed + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      v_q       <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept)
        v_q <= 1'b1;
      else if (complete || timeout)
        v_q <= 1'b0;
      if (complete)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q   <= pc;
      y_q    <= y;
      dest_q <= ir[RC_LSB +: RA_W];
      ld_q   <= op_ld;
      st_q   <= op_st;
      jmp_q  <= op_jmp;
    end
  end

  assign rf_we      = complete && wr_ok;
  assign rf_w_addr  = dest_q;
  assign rf_w_data  = ld_q  ? mem_rdata :
                      jmp_q ? pc_q      : y_q;
  assign pend_valid = v_q && wr_ok;
  assign pend_addr  = dest_q;
  assign ld_err     = timeout;
  assign instret    = instret_q;

endmodule

// File: tb/tb_wb_stage_p.sv
// Randomized scoreboard bench for wb_stage_p.
// Directed reset/ALU/reset-mid-wait checks, then random traffic.
module tb_wb_stage_p;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int T  = 15;
  localparam int CW = 4;

  logic          clk = 0;
  logic          rst;
  logic          in_valid, in_ready;
  logic          op_ld, op_st, op_jmp;
  logic [DW-1:0] pc, ir, y, mem_rdata;
  logic          mem_rvalid;
  logic          rf_we;
  logic [AW-1:0] rf_w_addr;
  logic [DW-1:0] rf_w_data;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic          ld_err;
  logic [CW-1:0] instret;

  wb_stage_p #(.CNT_W(CW), .LD_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_ld(op_ld), .op_st(op_st), .op_jmp(op_jmp),
    .pc(pc), .ir(ir), .y(y),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .pend_valid(pend_valid), .pend_addr(pend_addr),
    .ld_err(ld_err), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          err;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // monitor: every visible retirement event pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en && (rf_we || ld_err)) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: we=%0b err=%0b queue empty",
                   rf_we, ld_err);
        end else begin
          e = sb.pop_front();
          chk("mon_ld_err", 64'(ld_err), 64'(e.err));
          chk("mon_rf_we", 64'(rf_we), 64'(!e.err));
          if (!e.err) begin
            chk("mon_addr", 64'(rf_w_addr), 64'(e.addr));
            chk("mon_data", 64'(rf_w_data), 64'(e.data));
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    in_valid   = 0;
    op_ld      = 0;
    op_st      = 0;
    op_jmp     = 0;
    pc         = '0;
    ir         = '0;
    y          = '0;
    mem_rdata  = '0;
    mem_rvalid = 0;
  endtask

  function automatic logic [DW-1:0] mk_ir(input logic [AW-1:0] d);
    logic [DW-1:0] w;
    w = $urandom;
    w[25:21] = d;
    return w;
  endfunction

  // reference state: one held instruction and its pre-chosen load timing
  bit            held;
  int            age;
  bit            h_ld, h_st;
  int            h_lat;
  logic [DW-1:0] h_data;
  logic [AW-1:0] h_dest;
  int            exp_cnt;

  initial begin
    bit            rv, comp, drop, rdy, acc, pend;
    int            pick, kind;
    logic [AW-1:0] d;
    exp_t          e;

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #2;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_pend", 64'(pend_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_ld_err", 64'(ld_err), 64'd0);

    // single ALU op, dest 5
    in_valid = 1;
    ir = mk_ir(5'd5);
    y  = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #2;
    chk("alu_we", 64'(rf_we), 64'd1);
    chk("alu_addr", 64'(rf_w_addr), 64'd5);
    chk("alu_data", 64'(rf_w_data), 64'h1234);
    @(negedge clk);
    #2;
    chk("alu_instret", 64'(instret), 64'd1);

    // load held three cycles, then reset discards it
    in_valid = 1;
    op_ld = 1;
    ir = mk_ir(5'd7);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      #2;
      chk("wait_ready", 64'(in_ready), 64'd0);
      chk("wait_pend", 64'(pend_valid), 64'd1);
      chk("wait_paddr", 64'(pend_addr), 64'd7);
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    mem_rvalid = 1;
    mem_rdata = 32'hDEADBEEF;
    #2;
    chk("rstw_rf_we", 64'(rf_we), 64'd0);
    chk("rstw_pend", 64'(pend_valid), 64'd0);
    chk("rstw_ready", 64'(in_ready), 64'd1);
    chk("rstw_instret", 64'(instret), 64'd0);

    // random phase
    held    = 0;
    age     = 0;
    exp_cnt = 0;
    mon_en  = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (held && h_ld) rv = (age == h_lat);
      else rv = ($urandom_range(0, 3) == 0);
      mem_rvalid = rv;
      mem_rdata  = (held && h_ld && rv) ? h_data : DW'($urandom);
      comp = held && (!h_ld || age == h_lat);
      drop = held && h_ld && !comp && age == T;
      rdy  = !held || comp || drop;
      pend = held && !h_st && h_dest != 5'd31;

      in_valid = (cyc < 2970) && ($urandom_range(0, 4) != 0);
      kind   = $urandom_range(0, 5);
      op_ld  = (kind == 0 || kind == 1);
      op_st  = (kind == 2);
      op_jmp = (kind == 3);
      d  = ($urandom_range(0, 5) == 0) ? 5'd31 : AW'($urandom);
      ir = mk_ir(d);
      pc = $urandom;
      y  = $urandom;

      #2;
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("pend_valid", 64'(pend_valid), 64'(pend));
      if (pend) chk("pend_addr", 64'(pend_addr), 64'(h_dest));
      chk("instret", 64'(instret), 64'(exp_cnt % (1 << CW)));

      acc = in_valid && rdy;
      @(posedge clk);
      if (comp) exp_cnt++;
      if (acc) begin
        held   = 1;
        age    = 1;
        h_ld   = op_ld;
        h_st   = op_st;
        h_dest = d;
        h_data = $urandom;
        pick   = $urandom_range(0, 9);
        if (pick < 5) h_lat = pick + 1;
        else if (pick == 5) h_lat = T - 1;
        else if (pick == 6) h_lat = T;
        else if (pick == 7) h_lat = T + 1;
        else h_lat = $urandom_range(1, T + 3);
        if (op_ld && h_lat > T) begin
          e.err = 1; e.addr = d; e.data = '0;
          sb.push_back(e);
        end else if (!op_st && d != 5'd31) begin
          e.err  = 0;
          e.addr = d;
          e.data = op_ld ? h_data : op_jmp ? pc : y;
          sb.push_back(e);
        end
      end else if (comp || drop) begin
        held = 0;
      end else if (held) begin
        age++;
      end
    end
    idle_inputs();
    @(negedge clk);
    #4;
    mon_en = 0;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("final_instret", 64'(instret), 64'(exp_cnt % (1 << CW)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
